// File: rtl/tff_count_ctrl_pkg.sv
// Shared types for the T flip-flop counter controller: FSM state encoding.
package tff_count_ctrl_pkg;
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/tff_count_ctrl_cell.sv
// Single T flip-flop cell: q toggles on a rising clk edge whenever tin is high.
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic tin,
  output logic q
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      q <= 1'b0;
    else if (tin)
      q <= ~q;
  end
endmodule

// File: rtl/tff_count_ctrl.sv
// Programmable counter built from WIDTH T flip-flop cells; the controller only steers toggle enables.
// Optional down-count mode with a dir port is enabled by defining TFF_COUNT_CTRL_DOWN_EN.
module tff_count_ctrl
  import tff_count_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             oneshot,
`ifdef TFF_COUNT_CTRL_DOWN_EN
  input  logic             dir,
`endif
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tc_pulse
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] limit_q;
  logic             oneshot_q;
  logic             down;
  logic [WIDTH-1:0] tin;
  logic [WIDTH-1:0] step_vec;
  logic [WIDTH-1:0] wrap_vec;
  logic [WIDTH-1:0] start_vec;
  logic             chain;
  logic             at_term;
  logic             tc_set;
  logic             load;

`ifdef TFF_COUNT_CTRL_DOWN_EN
  logic dir_q;
  assign down      = dir_q;
  assign start_vec = dir ? (count ^ limit) : count;
`else
  assign down      = 1'b0;
  assign start_vec = count;
`endif

  // Toggle a bit when all lower bits are 1 (up) or all are 0 (down).
  always_comb begin
    step_vec = '0;
    chain    = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      step_vec[i] = chain;
      chain       = chain & (down ? ~count[i] : count[i]);
    end
  end

  assign at_term  = down ? (count == '0) : (count == limit_q);
  assign wrap_vec = down ? (count ^ limit_q) : count;

  always_comb begin
    state_nxt = state;
    tin       = '0;
    tc_set    = 1'b0;
    load      = 1'b0;
    if (stop) begin
      tin       = count;
      state_nxt = IDLE;
    end else if (start) begin
      tin       = start_vec;
      state_nxt = RUN;
      load      = 1'b1;
    end else begin
      case (state)
        RUN, HOLD: begin
          if (pause) begin
            state_nxt = HOLD;
          end else begin
            state_nxt = RUN;
            if (at_term) begin
              tc_set = 1'b1;
              if (oneshot_q)
                state_nxt = DONE;
              else
                tin = wrap_vec;
            end else begin
              tin = step_vec;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      limit_q   <= '0;
      oneshot_q <= 1'b0;
      tc_pulse  <= 1'b0;
`ifdef TFF_COUNT_CTRL_DOWN_EN
      dir_q     <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      tc_pulse <= tc_set;
      if (load) begin
        limit_q   <= limit;
        oneshot_q <= oneshot;
`ifdef TFF_COUNT_CTRL_DOWN_EN
        dir_q     <= dir;
`endif
      end
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    tff_cell u_cell (
      .clk (clk),
      .rst (rst),
      .tin (tin[g]),
      .q   (count[g])
    );
  end

  assign busy = (state == RUN) || (state == HOLD);
  assign done = (state == DONE);

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Scoreboard bench for tff_count_ctrl: stimulus pushes hand-computed expectations, a monitor pops and compares.
module tb_tff_count_ctrl;
  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, stop, pause, oneshot, dir;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic             busy, done, tc_pulse;

  typedef struct {
    logic [WIDTH-1:0] cnt;
    logic             busy;
    logic             done;
    logic             tc;
    string            tag;
  } exp_t;

  exp_t expQ[$];
  int   testsRun    = 0;
  int   testsFailed = 0;

  always #5 clk = ~clk;

  tff_count_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .oneshot  (oneshot),
`ifdef TFF_COUNT_CTRL_DOWN_EN
    .dir      (dir),
`endif
    .limit    (limit),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .tc_pulse (tc_pulse)
  );

  task automatic checkOutput(input exp_t e);
    testsRun++;
    if (count !== e.cnt || busy !== e.busy || done !== e.done || tc_pulse !== e.tc) begin
      testsFailed++;
      $display("[TB] FAIL %s: got count=%0d busy=%b done=%b tc=%b, expected count=%0d busy=%b done=%b tc=%b",
               e.tag, count, busy, done, tc_pulse, e.cnt, e.busy, e.done, e.tc);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the state expected after the next rising edge.
  task automatic applyStimulus(input logic st, input logic sp, input logic pa, input logic os,
                               input logic [WIDTH-1:0] lim, input logic [WIDTH-1:0] ec,
                               input logic eb, input logic ed, input logic et, input string tag);
    exp_t e;
    @(negedge clk);
    start   = st;
    stop    = sp;
    pause   = pa;
    oneshot = os;
    limit   = lim;
    e.cnt   = ec;
    e.busy  = eb;
    e.done  = ed;
    e.tc    = et;
    e.tag   = tag;
    expQ.push_back(e);
  endtask

  task automatic idleStep(input logic [WIDTH-1:0] ec, input logic eb, input logic ed,
                          input logic et, input string tag);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, ec, eb, ed, et, tag);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    exp_t e;
    rst = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; oneshot = 1'b0; dir = 1'b0; limit = '0;
    repeat (2) @(negedge clk);
    e = '{cnt: 4'd0, busy: 1'b0, done: 1'b0, tc: 1'b0, tag: "reset_state"};
    checkOutput(e);
    rst = 1'b1;

    // Periodic, limit 5
    applyStimulus(1, 0, 0, 0, 4'd5, 4'd0, 1, 0, 0, "per_start");
    for (int r = 0; r < 2; r++) begin
      for (int k = 1; k <= 5; k++) idleStep(4'(k), 1, 0, 0, "per_count");
      idleStep(4'd0, 1, 0, 1, "per_wrap_tc");
    end
    idleStep(4'd1, 1, 0, 0, "per_after_wrap");
    applyStimulus(0, 1, 0, 0, 4'd0, 4'd0, 0, 0, 0, "per_stop");

    // One-shot, limit 3, then restart from DONE and restart mid-run
    applyStimulus(1, 0, 0, 1, 4'd3, 4'd0, 1, 0, 0, "os_start");
    for (int k = 1; k <= 3; k++) idleStep(4'(k), 1, 0, 0, "os_count");
    idleStep(4'd3, 0, 1, 1, "os_done_tc");
    idleStep(4'd3, 0, 1, 0, "os_done_hold");
    idleStep(4'd3, 0, 1, 0, "os_done_hold2");
    applyStimulus(1, 0, 0, 1, 4'd3, 4'd0, 1, 0, 0, "os_restart_from_done");
    idleStep(4'd1, 1, 0, 0, "os_rerun1");
    idleStep(4'd2, 1, 0, 0, "os_rerun2");
    applyStimulus(1, 0, 0, 0, 4'd9, 4'd0, 1, 0, 0, "restart_mid_run");
    idleStep(4'd1, 1, 0, 0, "restart_count1");
    applyStimulus(0, 1, 0, 0, 4'd0, 4'd0, 0, 0, 0, "os_stop");

    // Pause at count 2 for four cycles
    applyStimulus(1, 0, 0, 0, 4'd9, 4'd0, 1, 0, 0, "pause_start");
    idleStep(4'd1, 1, 0, 0, "pause_pre1");
    idleStep(4'd2, 1, 0, 0, "pause_pre2");
    for (int k = 0; k < 4; k++) applyStimulus(0, 0, 1, 0, 4'd0, 4'd2, 1, 0, 0, "pause_hold");
    idleStep(4'd3, 1, 0, 0, "pause_release");
    for (int k = 4; k <= 6; k++) idleStep(4'(k), 1, 0, 0, "pause_post");

    // Stop and start together at count 6: stop wins
    applyStimulus(1, 1, 0, 0, 4'd9, 4'd0, 0, 0, 0, "stop_start_collide");
    idleStep(4'd0, 0, 0, 0, "collide_idle");

    // limit 0 periodic and one-shot
    applyStimulus(1, 0, 0, 0, 4'd0, 4'd0, 1, 0, 0, "lim0_per_start");
    for (int k = 0; k < 3; k++) idleStep(4'd0, 1, 0, 1, "lim0_per_tc");
    applyStimulus(0, 1, 0, 0, 4'd0, 4'd0, 0, 0, 0, "lim0_per_stop");
    applyStimulus(1, 0, 0, 1, 4'd0, 4'd0, 1, 0, 0, "lim0_os_start");
    idleStep(4'd0, 0, 1, 1, "lim0_os_done");
    idleStep(4'd0, 0, 1, 0, "lim0_os_hold");
    applyStimulus(0, 1, 0, 0, 4'd0, 4'd0, 0, 0, 0, "lim0_os_stop");

    // All-ones limit wraps 15 -> 0
    applyStimulus(1, 0, 0, 0, 4'd15, 4'd0, 1, 0, 0, "max_start");
    for (int k = 1; k <= 15; k++) idleStep(4'(k), 1, 0, 0, "max_count");
    idleStep(4'd0, 1, 0, 1, "max_wrap_tc");
    idleStep(4'd1, 1, 0, 0, "max_after_wrap");
    applyStimulus(0, 1, 0, 0, 4'd0, 4'd0, 0, 0, 0, "max_stop");

`ifdef TFF_COUNT_CTRL_DOWN_EN
    // Down count: periodic limit 9, then one-shot limit 2
    dir = 1'b1;
    applyStimulus(1, 0, 0, 0, 4'd9, 4'd9, 1, 0, 0, "dn_start_load");
    for (int k = 8; k >= 0; k--) idleStep(4'(k), 1, 0, 0, "dn_count");
    idleStep(4'd9, 1, 0, 1, "dn_reload_tc");
    idleStep(4'd8, 1, 0, 0, "dn_after_reload");
    applyStimulus(0, 1, 0, 0, 4'd0, 4'd0, 0, 0, 0, "dn_stop");
    applyStimulus(1, 0, 0, 1, 4'd2, 4'd2, 1, 0, 0, "dn_os_start");
    idleStep(4'd1, 1, 0, 0, "dn_os_1");
    idleStep(4'd0, 1, 0, 0, "dn_os_0");
    idleStep(4'd0, 0, 1, 1, "dn_os_done");
    idleStep(4'd0, 0, 1, 0, "dn_os_hold");
    applyStimulus(0, 1, 0, 0, 4'd0, 4'd0, 0, 0, 0, "dn_os_stop");
    dir = 1'b0;
`endif

    // Asynchronous reset in the middle of a run
    applyStimulus(1, 0, 0, 0, 4'd9, 4'd0, 1, 0, 0, "arst_start");
    for (int k = 1; k <= 3; k++) idleStep(4'(k), 1, 0, 0, "arst_count");
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    e = '{cnt: 4'd0, busy: 1'b0, done: 1'b0, tc: 1'b0, tag: "async_reset_mid_run"};
    checkOutput(e);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    idleStep(4'd0, 0, 0, 0, "post_reset_idle");
    idleStep(4'd0, 0, 0, 0, "post_reset_idle2");

    for (int k = 0; k < 10 && expQ.size() > 0; k++) @(posedge clk);
    #2;
    if (expQ.size() > 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL drain: %0d expectations left in queue, expected 0", expQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
